// File: rtl/clock_tap_tuner.sv
// Closed-loop delay-line tap controller: measures clk cycles per reference window
// and steps a one-hot tap select (linear or binary search) until the count is in band.
module clock_tap_tuner #(
    parameter int TAPS      = 512,
    parameter int CNT_W     = 32,
    parameter int RESET_TAP = TAPS - 1,
    parameter int LOCK_N    = 4,
    parameter int SETTLE    = 16,
    localparam int TW       = $clog2(TAPS)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             enable,
    input  logic             win_async,
    input  logic [CNT_W-1:0] target,
    input  logic [CNT_W-1:0] tol,
    input  logic [TW-1:0]    init_tap,
    input  logic             mode,
    output logic [TAPS-1:0]  tap_onehot,
    output logic [TW-1:0]    tap_idx,
    output logic             locked,
    output logic             at_min,
    output logic             at_max,
    output logic             err,
    output logic [CNT_W-1:0] meas_cnt,
    output logic             meas_valid
);

    localparam int SW = $clog2(SETTLE + 1);
    localparam int LW = $clog2(LOCK_N + 1);
    localparam logic [TW:0] MAX_TAP = (TW+1)'(TAPS - 1);

    typedef enum logic [2:0] {S_IDLE, S_ARM, S_WAIT, S_COUNT, S_EVAL} state_t;

    state_t           state;
    logic             win_m, win_s, win_q, en_q;
    logic [CNT_W-1:0] cnt;
    logic [TW:0]      step;
    logic [SW-1:0]    settle_cnt;
    logic [LW-1:0]    lock_cnt;

    logic             win_rise, win_fall, en_rise;
    logic [CNT_W:0]   hi_sum;
    logic [CNT_W-1:0] lo, hi;
    logic             above, below;
    logic [TW:0]      tap_w, up_w, dn_w;
    logic [TW-1:0]    init_clamped, tap_nxt;
    logic             err_req;
    logic [LW-1:0]    lock_inc;

    assign win_rise = win_s & ~win_q;
    assign win_fall = ~win_s & win_q;
    assign en_rise  = enable & ~en_q;

    // Band limits saturate at both ends so a wide tolerance never wraps.
    assign hi_sum = {1'b0, target} + {1'b0, tol};
    assign hi     = hi_sum[CNT_W] ? '1 : hi_sum[CNT_W-1:0];
    assign lo     = (target > tol) ? target - tol : '0;
    assign above  = cnt > hi;
    assign below  = cnt < lo;

    assign tap_w = {1'b0, tap_idx};
    assign up_w  = (tap_w + step > MAX_TAP) ? MAX_TAP : tap_w + step;
    assign dn_w  = (tap_w < step) ? '0 : tap_w - step;
    assign init_clamped = ({1'b0, init_tap} > MAX_TAP) ? MAX_TAP[TW-1:0] : init_tap;
    assign lock_inc = (lock_cnt == LW'(LOCK_N)) ? lock_cnt : lock_cnt + 1'b1;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        tap_nxt = tap_idx;
        err_req = 1'b0;
        if (state == S_IDLE && en_rise) begin
            tap_nxt = init_clamped;
        end else if (state == S_EVAL && enable) begin
            if (above) begin
                if (at_max) err_req = 1'b1;
                else        tap_nxt = up_w[TW-1:0];
            end else if (below) begin
                if (at_min) err_req = 1'b1;
                else        tap_nxt = dn_w[TW-1:0];
            end
        end
    end

    // NOTE: all state here uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= S_IDLE;
            win_m      <= 1'b0;
            win_s      <= 1'b0;
            win_q      <= 1'b0;
            en_q       <= 1'b0;
            cnt        <= '0;
            step       <= (TW+1)'(1);
            settle_cnt <= '0;
            lock_cnt   <= '0;
            tap_idx    <= TW'(RESET_TAP);
            tap_onehot <= TAPS'(1) << RESET_TAP;
            at_min     <= (RESET_TAP == 0);
            at_max     <= (RESET_TAP == TAPS - 1);
            locked     <= 1'b0;
            err        <= 1'b0;
            meas_cnt   <= '0;
            meas_valid <= 1'b0;
        end else begin
            win_m      <= win_async;
            win_s      <= win_m;
            win_q      <= win_s;
            en_q       <= enable;
            meas_valid <= 1'b0;
            tap_idx    <= tap_nxt;
            tap_onehot <= TAPS'(1) << tap_nxt;
            at_min     <= (tap_nxt == '0);
            at_max     <= ({1'b0, tap_nxt} == MAX_TAP);

            if (!enable) begin
                state  <= S_IDLE;
                locked <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: if (en_rise) begin
                        step       <= mode ? (TW+1)'(TAPS / 2) : (TW+1)'(1);
                        lock_cnt   <= '0;
                        locked     <= 1'b0;
                        err        <= 1'b0;
                        settle_cnt <= SW'(SETTLE - 1);
                        state      <= S_ARM;
                    end
                    // Settle, then wait for a low window so a partial window is never counted.
                    S_ARM: begin
                        if (settle_cnt != '0) settle_cnt <= settle_cnt - 1'b1;
                        else if (!win_s)      state      <= S_WAIT;
                    end
                    S_WAIT: if (win_rise) begin
                        cnt   <= CNT_W'(1);
                        state <= S_COUNT;
                    end
                    S_COUNT: begin
                        if (win_fall) begin
                            meas_cnt   <= cnt;
                            meas_valid <= 1'b1;
                            state      <= S_EVAL;
                        end else if (win_s && cnt != '1) begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    S_EVAL: begin
                        if (above || below) begin
                            lock_cnt <= '0;
                            locked   <= 1'b0;
                            if (step > (TW+1)'(1)) step <= step >> 1;
                        end else begin
                            step     <= (TW+1)'(1);
                            lock_cnt <= lock_inc;
                            locked   <= (lock_inc == LW'(LOCK_N));
                        end
                        if (err_req) err <= 1'b1;
                        settle_cnt <= SW'(SETTLE - 1);
                        state      <= (tap_nxt != tap_idx) ? S_ARM : S_WAIT;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_clock_tap_tuner.sv
// Directed self-checking bench for clock_tap_tuner (TAPS=512, SETTLE=16, LOCK_N=4);
// the plant is modelled by choosing each window length from the current tap.
module tb_clock_tap_tuner;

    logic         clk = 1'b0;
    logic         resetn, enable, win_async, mode;
    logic [31:0]  target, tol;
    logic [8:0]   init_tap;
    logic [511:0] tap_onehot;
    logic [8:0]   tap_idx;
    logic         locked, at_min, at_max, err, meas_valid;
    logic [31:0]  meas_cnt;

    int checks = 0;
    int errors = 0;
    int mv_count = 0;
    int bin_seq[7] = '{256, 128, 64, 96, 112, 104, 100};

    clock_tap_tuner dut (
        .clk(clk), .resetn(resetn), .enable(enable), .win_async(win_async),
        .target(target), .tol(tol), .init_tap(init_tap), .mode(mode),
        .tap_onehot(tap_onehot), .tap_idx(tap_idx), .locked(locked),
        .at_min(at_min), .at_max(at_max), .err(err),
        .meas_cnt(meas_cnt), .meas_valid(meas_valid)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (meas_valid === 1'b1) mv_count++;

    // Idle gap, a window of len clk cycles, then wait (bounded) for the measurement.
    task automatic run_window(input int len, output bit seen, output logic [31:0] mc);
        seen = 1'b0;
        mc   = '0;
        win_async = 1'b0;
        repeat (24) @(negedge clk);
        win_async = 1'b1;
        repeat (len) @(negedge clk);
        win_async = 1'b0;
        for (int i = 0; i < 16 && !seen; i++) begin
            @(negedge clk);
            if (meas_valid === 1'b1) begin
                seen = 1'b1;
                mc   = meas_cnt;
            end
        end
        if (seen) @(negedge clk);
    endtask

    task automatic start(input logic [8:0] it, input logic md);
        @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        init_tap = it;
        mode     = md;
        enable   = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset;
        logic [511:0] oh_exp;
        oh_exp = '0;
        oh_exp[511] = 1'b1;
        resetn = 1'b0; enable = 1'b0; win_async = 1'b0; mode = 1'b0;
        target = '0; tol = '0; init_tap = '0;
        #12;
        checks++; if (tap_idx !== 9'd511) begin errors++; $display("FAIL rst_tap got=%0d exp=511", tap_idx); end
        checks++; if (tap_onehot !== oh_exp) begin errors++; $display("FAIL rst_onehot got=%h", tap_onehot); end
        checks++; if ({at_max, at_min, locked, err, meas_valid} !== 5'b10000) begin
            errors++; $display("FAIL rst_flags got=%b exp=10000", {at_max, at_min, locked, err, meas_valid}); end
        checks++; if (meas_cnt !== 32'd0) begin errors++; $display("FAIL rst_meas got=%0d exp=0", meas_cnt); end
        @(negedge clk) resetn = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (tap_idx !== 9'd511 || tap_onehot[511] !== 1'b1 || at_max !== 1'b1 || locked !== 1'b0) begin
            errors++; $display("FAIL rel_state got tap=%0d oh511=%b at_max=%b locked=%b", tap_idx, tap_onehot[511], at_max, locked); end
    endtask

    task automatic test_band_sat;
        bit seen; logic [31:0] mc;
        start(9'd300, 1'b0);
        checks++; if (tap_idx !== 9'd300) begin errors++; $display("FAIL load_tap got=%0d exp=300", tap_idx); end
        // tol > target: low bound clamps to 0, a one-cycle pulse is in band.
        target = 32'd1; tol = 32'd5;
        run_window(1, seen, mc);
        checks++; if (!seen || mc !== 32'd1) begin errors++; $display("FAIL pulse_cnt seen=%0d got=%0d exp=1", seen, mc); end
        checks++; if (tap_idx !== 9'd300) begin errors++; $display("FAIL pulse_tap got=%0d exp=300", tap_idx); end
        // High bound saturates; count 3 is below lo=0xFFFFFEF0.
        target = 32'hFFFF_FFF0; tol = 32'h100;
        run_window(3, seen, mc);
        checks++; if (!seen || mc !== 32'd3) begin errors++; $display("FAIL sat_cnt seen=%0d got=%0d exp=3", seen, mc); end
        checks++; if (tap_idx !== 9'd299 || err !== 1'b0) begin errors++; $display("FAIL sat_tap got=%0d err=%b exp=299 0", tap_idx, err); end
    endtask

    task automatic test_linear;
        bit seen; logic [31:0] mc;
        start(9'd100, 1'b0);
        target = 32'd1000; tol = 32'd2;
        for (int i = 0; i < 3; i++) begin
            run_window(1010, seen, mc);
            checks++; if (!seen || mc !== 32'd1010) begin errors++; $display("FAIL lin_cnt[%0d] seen=%0d got=%0d exp=1010", i, seen, mc); end
            checks++; if (tap_idx !== 9'(101 + i) || locked !== 1'b0) begin
                errors++; $display("FAIL lin_tap[%0d] got=%0d locked=%b exp=%0d 0", i, tap_idx, locked, 101 + i); end
        end
        for (int j = 0; j < 4; j++) begin
            run_window(1001, seen, mc);
            checks++; if (!seen || tap_idx !== 9'd103 || locked !== (j == 3)) begin
                errors++; $display("FAIL lin_lock[%0d] seen=%0d tap=%0d locked=%b exp tap=103 locked=%0d", j, seen, tap_idx, locked, j == 3); end
        end
    endtask

    task automatic test_enable_drop;
        int mv0;
        mv0 = mv_count;
        win_async = 1'b0;
        repeat (24) @(negedge clk);
        win_async = 1'b1;
        repeat (10) @(negedge clk);
        enable = 1'b0;
        repeat (90) @(negedge clk);
        win_async = 1'b0;
        repeat (20) @(negedge clk);
        checks++; if (mv_count !== mv0) begin errors++; $display("FAIL drop_mv got=%0d exp=%0d", mv_count, mv0); end
        checks++; if (locked !== 1'b0 || tap_idx !== 9'd103 || meas_cnt !== 32'd1001) begin
            errors++; $display("FAIL drop_hold locked=%b tap=%0d meas=%0d exp 0 103 1001", locked, tap_idx, meas_cnt); end
    endtask

    task automatic test_binary;
        bit seen; logic [31:0] mc;
        start(9'd0, 1'b1);
        checks++; if (tap_idx !== 9'd0 || at_min !== 1'b1) begin errors++; $display("FAIL bin_load tap=%0d at_min=%b exp 0 1", tap_idx, at_min); end
        target = 32'd1000; tol = 32'd0;
        // Plant: count falls as delay grows, 1100 - tap; converges on tap 100.
        for (int i = 0; i < 7; i++) begin
            run_window(1100 - int'(tap_idx), seen, mc);
            checks++; if (!seen || tap_idx !== 9'(bin_seq[i])) begin
                errors++; $display("FAIL bin_step[%0d] seen=%0d got=%0d exp=%0d", i, seen, tap_idx, bin_seq[i]); end
        end
        for (int j = 0; j < 4; j++) begin
            run_window(1100 - int'(tap_idx), seen, mc);
            checks++; if (!seen || tap_idx !== 9'd100 || locked !== (j == 3)) begin
                errors++; $display("FAIL bin_lock[%0d] seen=%0d tap=%0d locked=%b exp tap=100 locked=%0d", j, seen, tap_idx, locked, j == 3); end
        end
    endtask

    task automatic test_err_end;
        bit seen; logic [31:0] mc;
        start(9'd511, 1'b0);
        target = 32'd10; tol = 32'd0;
        run_window(20, seen, mc);
        checks++; if (!seen || tap_idx !== 9'd511 || err !== 1'b1 || at_max !== 1'b1) begin
            errors++; $display("FAIL end_err1 seen=%0d tap=%0d err=%b at_max=%b exp 511 1 1", seen, tap_idx, err, at_max); end
        run_window(20, seen, mc);
        checks++; if (!seen || tap_idx !== 9'd511 || err !== 1'b1) begin
            errors++; $display("FAIL end_err2 seen=%0d tap=%0d err=%b exp 511 1", seen, tap_idx, err); end
        @(negedge clk) enable = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL end_err_hold got=%b exp=1", err); end
        enable = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL end_err_clear got=%b exp=0", err); end
    endtask

    task automatic test_settle;
        bit seen; logic [31:0] mc;
        int mv0;
        start(9'd200, 1'b0);
        target = 32'd10; tol = 32'd0;
        run_window(20, seen, mc);
        checks++; if (!seen || tap_idx !== 9'd201) begin errors++; $display("FAIL settle_move seen=%0d tap=%0d exp=201", seen, tap_idx); end
        mv0 = mv_count;
        repeat (3) @(negedge clk);
        win_async = 1'b1;
        repeat (30) @(negedge clk);
        win_async = 1'b0;
        repeat (40) @(negedge clk);
        checks++; if (mv_count !== mv0) begin errors++; $display("FAIL settle_ignored got=%0d exp=%0d", mv_count, mv0); end
        run_window(15, seen, mc);
        checks++; if (!seen || mc !== 32'd15 || tap_idx !== 9'd202) begin
            errors++; $display("FAIL settle_next seen=%0d cnt=%0d tap=%0d exp 15 202", seen, mc, tap_idx); end
    endtask

    task automatic test_reset_mid;
        logic [511:0] oh_exp;
        oh_exp = '0;
        oh_exp[511] = 1'b1;
        start(9'd50, 1'b0);
        win_async = 1'b0;
        repeat (24) @(negedge clk);
        win_async = 1'b1;
        repeat (10) @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        checks++; if (tap_idx !== 9'd511 || tap_onehot !== oh_exp) begin
            errors++; $display("FAIL amid_tap got=%0d exp=511", tap_idx); end
        checks++; if ({at_max, at_min, locked, err, meas_valid} !== 5'b10000 || meas_cnt !== 32'd0) begin
            errors++; $display("FAIL amid_flags got=%b meas=%0d exp=10000 0", {at_max, at_min, locked, err, meas_valid}, meas_cnt); end
        win_async = 1'b0;
        @(negedge clk) resetn = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_band_sat();
        test_linear();
        test_enable_drop();
        test_binary();
        test_err_end();
        test_settle();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
